// File: rtl/cs_resolve_pkg.sv
// Shared types and sizing helpers for the carry-save resolve adder.
// Optional zero flag is enabled by defining CS_RESOLVE_ZERO_FLAG_EN.
package cs_resolve_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cs_state_t;

  // Number of CHUNK-wide slices needed to cover the (width+2)-bit result.
  function automatic int nchunk(input int width, input int chunk);
    return (width + 2 + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/cs_chunk_add.sv
// CHUNK-bit ripple adder built from full-adder cells, one slice of the resolve.
// Used by cs_resolve_adder (zero flag option CS_RESOLVE_ZERO_FLAG_EN lives there).
module cs_chunk_add
  import cs_resolve_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/cs_resolve_adder.sv
// Chunk-serial carry-propagate resolve of a carry-save pair: result = sum + 2*carry.
// Define CS_RESOLVE_ZERO_FLAG_EN to add the registered zero output.
//
// state | meaning
// IDLE  | in_ready high, waiting for a carry-save pair
// RUN   | one CHUNK-bit slice resolved per cycle, NCHUNK cycles
// DONE  | out_valid high, result held until out_ready
module cs_resolve_adder
  import cs_resolve_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result
`ifdef CS_RESOLVE_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int RW     = WIDTH + 2;
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  cs_state_t state, state_next;
  logic      accept;

  logic [NCHUNK-1:0][CHUNK-1:0] a_reg, b_reg, r_reg;
  logic [PW-1:0]                r_flat;
  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic                         cy;
  logic [CHUNK-1:0]             slice_sum;
  logic                         slice_co;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign idx = cnt[IW-1:0];

  cs_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .a  (a_reg[idx]),
    .b  (b_reg[idx]),
    .ci (cy),
    .s  (slice_sum),
    .co (slice_co)
  );

  // Operands are zero-padded to whole chunks so the top slice needs no special case.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
      r_reg <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
    end else if (accept) begin
      a_reg <= PW'(sum_in);
      b_reg <= PW'({carry_in, 1'b0});
      cnt   <= '0;
      cy    <= 1'b0;
    end else if (state == RUN) begin
      r_reg[idx] <= slice_sum;
      cy         <= slice_co;
      cnt        <= cnt + CW'(1);
    end
  end

  assign r_flat = r_reg;

  // Gate with out_valid so a stale or partially resolved value never shows.
  assign result = out_valid ? r_flat[RW-1:0] : '0;

  if (PW > RW) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^r_flat[PW-1:RW];
  end

`ifdef CS_RESOLVE_ZERO_FLAG_EN
  logic nz, zero_q;

  // Padding bits of the top slice are always zero, so OR-ing whole slices is exact.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nz     <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (accept)             nz <= 1'b0;
      else if (state == RUN)  nz <= nz | (|slice_sum);

      if (state == RUN && cnt == LAST)      zero_q <= ~(nz | (|slice_sum));
      else if (state != DONE || out_ready)  zero_q <= 1'b0;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_cs_resolve_adder.sv
// Scoreboard bench for cs_resolve_adder with directed carry-save vectors.
// Also checks zero when built with CS_RESOLVE_ZERO_FLAG_EN.
module tb_cs_resolve_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int RW     = WIDTH + 2;
  localparam int NCHUNK = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    result;
`ifdef CS_RESOLVE_ZERO_FLAG_EN
  logic             zero;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_t = 0;
  logic prev_ov = 1'b0;
  logic [RW-1:0] exp_q[$];

  cs_resolve_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef CS_RESOLVE_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Monitor: latency of each rising out_valid, and scoreboard pop on handshake.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (!reset_n) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_t = cyc;
      if (out_valid && !prev_ov) check("latency", cyc - acc_t, NCHUNK + 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e));
`ifdef CS_RESOLVE_ZERO_FLAG_EN
          check("zero", 32'(zero), 32'(e == '0));
`endif
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                      input logic [RW-1:0] exp, input bit push);
    int n = 0;
    forever begin
      @(posedge clk); #1;
      if (in_ready) break;
      n++;
      if (n > 50) begin
        fail_now("send_wait_ready");
        return;
      end
    end
    in_valid = 1'b1;
    sum_in   = s;
    carry_in = c;
    @(posedge clk);
    if (push) exp_q.push_back(exp);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    sum_in    = '0;
    carry_in  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_result", 32'(result), 0);

    send(16'h0001, 16'h0000, 18'h00001, 1'b1);
    send(16'hFFFF, 16'hFFFF, 18'h2FFFD, 1'b1);
    send(16'h00FF, 16'h0080, 18'h001FF, 1'b1);
    send(16'h000F, 16'h0008, 18'h0001F, 1'b1);
    send(16'hAAAA, 16'h5555, 18'h15554, 1'b1);
    send(16'h1234, 16'h0F0F, 18'h03052, 1'b1);
    drain();

    // Back-pressure in DONE with a competing in_valid that must be ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    send(16'h8000, 16'h4000, 18'h10000, 1'b1);
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 20) begin
        fail_now("wait_out_valid");
        break;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      sum_in   = 16'h1111;
      carry_in = 16'h1111;
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_result", 32'(result), 32'h10000);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("drop_out_valid", 32'(out_valid), 0);
    check("drop_in_ready", 32'(in_ready), 1);
    drain();

    // Reset during the second RUN cycle aborts with nothing presented.
    send(16'hFFFF, 16'h0000, 18'h0FFFF, 1'b0);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_result", 32'(result), 0);
    send(16'h0003, 16'h0001, 18'h00005, 1'b1);

    send(16'h0000, 16'h0000, 18'h00000, 1'b1);
    send(16'h8000, 16'h0000, 18'h08000, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
